// File: rtl/oh_irq_pkg.sv
// oh_irq_pkg: shared definitions for the oh_irq_collect interrupt collector.
//   - state_t : FSM encoding IDLE=2'b00, HOLD=2'b01, ASSERT=2'b10
//               (2'b11 is illegal and recovers to IDLE)
//   - DEF_DW  : default number of event bits
//   - DEF_CW  : default holdoff counter width
package oh_irq_pkg;

  localparam int DEF_DW = 1;
  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    ASSERT = 2'b10
  } state_t;

endpackage

// File: rtl/oh_edgedetect.sv
// oh_edgedetect: DW-wide rising-edge detector.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset; clears the history register
//   din   - input levels
//   rise  - combinational, high for one cycle when din goes 0 -> 1
module oh_edgedetect #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] rise
);

  logic [DW-1:0] din_q;

  // One-cycle history of the input levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= {DW{1'b0}};
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/oh_irq_collect.sv
// oh_irq_collect: sticky event collector with interrupt coalescing.
// Captures event flags into a sticky pending register, gates them with a
// per-bit mask and raises a registered irq after a programmable holdoff.
// Build option: define OH_IRQ_COLLECT_EDGE_EN to capture rising edges of
// event_in instead of levels.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset (highest priority)
//   event_in  - event flags, DW bits
//   mask      - per-bit irq enable (does not affect pending)
//   clr_valid - qualifies clr_mask
//   clr_mask  - write-1-to-clear pattern for pending
//   holdoff   - coalescing delay, sampled on IDLE -> HOLD
//   pending   - sticky pending register
//   irq       - registered interrupt request (state == ASSERT)
module oh_irq_collect
  import oh_irq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] event_in,
  input  logic [DW-1:0] mask,
  input  logic          clr_valid,
  input  logic [DW-1:0] clr_mask,
  input  logic [CW-1:0] holdoff,
  output logic [DW-1:0] pending,
  output logic          irq
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [DW-1:0] set_bits;
  logic [DW-1:0] clr_eff;
  logic [DW-1:0] pending_next;
  logic          act;
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] counter;
  logic [CW-1:0] counter_next;

`ifdef OH_IRQ_COLLECT_EDGE_EN
  oh_edgedetect #(.DW(DW)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (event_in),
    .rise  (set_bits)
  );
`else
  assign set_bits = event_in;
`endif

  // Set is ORed in after the clear so a colliding event is never lost.
  assign clr_eff      = clr_valid ? clr_mask : {DW{1'b0}};
  assign pending_next = (pending & ~clr_eff) | set_bits;
  assign act          = |(pending & mask);

  // Next-state and holdoff counter logic.
  always_comb begin
    state_next   = state;
    counter_next = CNT_ZERO;
    case (state)
      IDLE: begin
        if (act) begin
          if (holdoff == CNT_ZERO) begin
            state_next = ASSERT;
          end else begin
            state_next   = HOLD;
            counter_next = holdoff;
          end
        end else begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (!act) begin
          state_next = IDLE;
        end else if (counter == CNT_ONE) begin
          state_next = ASSERT;
        end else begin
          state_next = HOLD;
          // Decrement saturates at 1 so the counter can never wrap.
          counter_next = (counter > CNT_ONE) ? (counter - CNT_ONE) : counter;
        end
      end
      ASSERT: begin
        if (act) begin
          state_next = ASSERT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter, pending and irq registers. irq is taken from the
  // next state so it tracks the ASSERT state cycle-for-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= CNT_ZERO;
      pending <= {DW{1'b0}};
      irq     <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      pending <= pending_next;
      irq     <= (state_next == ASSERT);
    end
  end

endmodule
